r4_bin_collector: RTL and testbench
===================================

# r4_bin_collector

Sequencer and result collector for the radix-4 butterfly output port. The butterfly presents one output bin at a time on a 4-bit real/imag pair, selected by its three control lines. This block steps those select lines through all four bins, waits a settle interval per bin, and captures each result into a 4-bin frame register. It then offers the frame on a valid/ready handshake toward the logic-analyzer/Wishbone readout side.

## Interface
Parameters:
- `DW`, 4, data width of each real/imag sample (two's complement, captured raw)
- `SETTLE`, 1, cycles each bin select is held before capture; legal range 1..15

Ports:
- `wb_clk_i`  in  1  single clock, rising edge
- `wb_rst_ni`  in  1  reset, asynchronous assert, active-low
- `start_i`  in  1  one-cycle request to collect a frame
- `clr_i`  in  1  synchronous clear of `overrun_o`
- `sel_o`  out  3  butterfly select, `{c3,c2,c1}`
- `xr_i`  in  DW  butterfly real output (Xro)
- `xi_i`  in  DW  butterfly imag output (Xio)
- `busy_o`  out  1  high in any state other than IDLE
- `frame_valid_o`  out  1  frame available
- `frame_ready_i`  in  1  consumer accepts frame
- `frame_xr_o`  out  4*DW  real bins; bin k at `[k*DW +: DW]`
- `frame_xi_o`  out  4*DW  imag bins, same packing
- `overrun_o`  out  1  sticky: `start_i` was dropped

## Operation
- States: IDLE, SETTLE, FULL. Internal `bin` (2 bits) and `cnt` (4 bits).
- IDLE, `start_i`=1: go to SETTLE with `bin`=0, `sel_o`=BIN_SEL[0], `cnt`=SETTLE-1.
- SETTLE, `cnt`!=0: decrement `cnt`.
- SETTLE, `cnt`==0:
  - Write `xr_i`/`xi_i` into slot `bin`.
  - If `bin`<3: increment `bin`, set `sel_o`=BIN_SEL[bin+1], reload `cnt`.
  - If `bin`==3: go to FULL.
- FULL: `frame_valid_o`=1. The handshake completes when `frame_ready_i`=1.
  - Handshake with `start_i`=0: go to IDLE.
  - Handshake with `start_i`=1 in the same cycle: go directly to SETTLE for a new frame, with the same initialisation as from IDLE. `overrun_o` does not set.
- `start_i` in SETTLE, or in FULL without a handshake, is dropped and sets `overrun_o`.
  - `clr_i` clears `overrun_o`.
  - If `clr_i` and a dropped start occur together, set wins.
- BIN_SEL codes: bin0=3'b000, bin1=3'b001, bin2=3'b010, bin3=3'b100.
- `sel_o` holds its last value in IDLE and FULL.
- Frame registers change only on capture.
  - They are stable whenever `frame_valid_o`=1.
  - They retain their contents after the handshake.
- No arithmetic: samples are stored bit-exact.

## Timing
- Reset values: state IDLE, `sel_o`=3'b000, `busy_o`=0, `frame_valid_o`=0, `overrun_o`=0, frame registers all 0, `bin`=0, `cnt`=0.
- All outputs are registered. `busy_o` and `frame_valid_o` are decoded from the state register only.
- Start sampled at edge E0:
  - `sel_o` for bin k is valid from edge E0+k·SETTLE.
  - Bin k is captured at edge E0+(k+1)·SETTLE.
  - `frame_valid_o` rises after edge E0+4·SETTLE, i.e. 4 cycles for SETTLE=1.
- Capture samples `xr_i`/`xi_i` at the edge that ends the SETTLE-th cycle of that bin's select. The butterfly path must meet one cycle from `sel_o`.
- Back-to-back throughput with ready held high: one frame per 4·SETTLE+… cycles, with no idle cycle between frames.
- Reset asserted mid-frame: immediate return to reset values and partial frame discarded. After deassertion the block waits for a fresh `start_i`.

## Structure
- Package `r4_pkg`: state enum (IDLE/SETTLE/FULL), `BIN_SEL` constant array, `NBINS`=4.
- Single module. The frame store is a flat register array inside it; no sub-module.

## Test plan
- Reset, then `start_i` with SETTLE=1, and a model returning xr=bin+1, xi=−(bin+1):
  - `sel_o` steps 000, 001, 010, 100 on consecutive cycles.
  - `frame_valid_o` rises after 4 cycles.
  - `frame_xr_o`=16'h4321, `frame_xi_o`=16'hCDEF.
- SETTLE=3, with the model changing output one cycle after `sel_o`: the captured values equal the settled values; `frame_valid_o` rises at 12 cycles.
- Hold `frame_ready_i`=0 for 5 cycles in FULL:
  - Frame outputs are stable.
  - `start_i` pulsed mid-hold sets `overrun_o`.
  - `clr_i` clears it.
- `frame_ready_i`=1 and `start_i`=1 in the same FULL cycle: next cycle is SETTLE with bin0, `overrun_o` stays 0, and there is no IDLE cycle.
- Assert `wb_rst_ni`=0 during bin 2 capture: all outputs go to reset values asynchronously; a later start produces a clean frame.

Source files
------------

// File: rtl/r4_bin_collector_pkg.sv
// Shared types and constants for the radix-4 butterfly result collector.
package r4_pkg;

   localparam int NBINS = 4;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETTLE,
      ST_FULL
   } state_t;

   // Butterfly select codes {c3,c2,c1}, indexed by output bin.
   localparam logic [2:0] BIN_SEL [NBINS] = '{3'b000, 3'b001, 3'b010, 3'b100};

endpackage

// File: rtl/r4_bin_collector.sv
// Steps the butterfly select through four bins, captures each settled result
// into a frame register and offers the frame on a valid/ready handshake.
module r4_bin_collector
   import r4_pkg::*;
#(
   parameter int DW     = 4,
   parameter int SETTLE = 1
) (
   input  logic              wb_clk_i,
   input  logic              wb_rst_ni,
   input  logic              start_i,
   input  logic              clr_i,
   output logic [2:0]        sel_o,
   input  logic [DW-1:0]     xr_i,
   input  logic [DW-1:0]     xi_i,
   output logic              busy_o,
   output logic              frame_valid_o,
   input  logic              frame_ready_i,
   output logic [4*DW-1:0]   frame_xr_o,
   output logic [4*DW-1:0]   frame_xi_o,
   output logic              overrun_o
);

   localparam logic [3:0] CNT_RELOAD = 4'(SETTLE - 1);

   state_t                 state_q;
   logic [1:0]             bin_q;
   logic [3:0]             cnt_q;
   logic [2:0]             sel_q;
   logic                   overrun_q;
   logic [NBINS*DW-1:0]    frame_xr_q;
   logic [NBINS*DW-1:0]    frame_xi_q;

   logic                   handshake;
   logic                   start_ok;
   logic                   start_drop;

   assign handshake  = (state_q == ST_FULL) && frame_ready_i;
   // A start is taken in IDLE, or in FULL when the current frame is consumed
   // in the same cycle; anywhere else it is lost.
   assign start_ok   = start_i && ((state_q == ST_IDLE) || handshake);
   assign start_drop = start_i && !start_ok;

   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         state_q    <= ST_IDLE;
         bin_q      <= 2'd0;
         cnt_q      <= 4'd0;
         sel_q      <= 3'b000;
         overrun_q  <= 1'b0;
         frame_xr_q <= '0;
         frame_xi_q <= '0;
      end else begin
         if (start_drop) begin
            overrun_q <= 1'b1;
         end else if (clr_i) begin
            overrun_q <= 1'b0;
         end

         case (state_q)
            ST_IDLE, ST_FULL: begin
               if (start_ok) begin
                  state_q <= ST_SETTLE;
                  bin_q   <= 2'd0;
                  sel_q   <= BIN_SEL[0];
                  cnt_q   <= CNT_RELOAD;
               end else if (handshake) begin
                  state_q <= ST_IDLE;
               end
            end
            ST_SETTLE: begin
               if (cnt_q != 4'd0) begin
                  cnt_q <= cnt_q - 4'd1;
               end else begin
                  frame_xr_q[bin_q*DW +: DW] <= xr_i;
                  frame_xi_q[bin_q*DW +: DW] <= xi_i;
                  if (bin_q != 2'd3) begin
                     bin_q <= bin_q + 2'd1;
                     sel_q <= BIN_SEL[bin_q + 2'd1];
                     cnt_q <= CNT_RELOAD;
                  end else begin
                     state_q <= ST_FULL;
                  end
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign sel_o         = sel_q;
   assign busy_o        = (state_q != ST_IDLE);
   assign frame_valid_o = (state_q == ST_FULL);
   assign frame_xr_o    = frame_xr_q;
   assign frame_xi_o    = frame_xi_q;
   assign overrun_o     = overrun_q;

endmodule

// File: tb/tb_r4_bin_collector.sv
// Bench for r4_bin_collector: SETTLE=1 and SETTLE=3 instances with butterfly models.
module tb_r4_bin_collector;

   typedef struct {
      bit         start;
      bit         ready;
      bit         clr;
      bit         push;
      int         ofs;
      logic [2:0] sel;
      bit         busy;
      bit         valid;
      bit         ovr;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n;
   int          total = 0;
   int          bad = 0;
   int          ofs = 0;
   logic [31:0] sb_q[$];

   logic        start1, clr1, ready1, busy1, valid1, ovr1;
   logic [2:0]  sel1;
   logic [3:0]  xr1, xi1;
   logic [15:0] fxr1, fxi1;

   logic        start3, clr3, ready3, busy3, valid3, ovr3;
   logic [2:0]  sel3;
   logic [3:0]  xr3 = 4'h0;
   logic [3:0]  xi3 = 4'h0;
   logic [15:0] fxr3, fxi3;

   logic [3:0]  tab_xr [4] = '{4'h5, 4'hA, 4'h3, 4'hC};
   logic [3:0]  tab_xi [4] = '{4'h9, 4'h2, 4'hE, 4'h7};
   logic [2:0]  bin_sel_ref [4] = '{3'b000, 3'b001, 3'b010, 3'b100};

   always #5 clk = ~clk;

   r4_bin_collector #(.DW(4), .SETTLE(1)) dut (
      .wb_clk_i(clk), .wb_rst_ni(rst_n), .start_i(start1), .clr_i(clr1),
      .sel_o(sel1), .xr_i(xr1), .xi_i(xi1), .busy_o(busy1),
      .frame_valid_o(valid1), .frame_ready_i(ready1),
      .frame_xr_o(fxr1), .frame_xi_o(fxi1), .overrun_o(ovr1));

   r4_bin_collector #(.DW(4), .SETTLE(3)) dut3 (
      .wb_clk_i(clk), .wb_rst_ni(rst_n), .start_i(start3), .clr_i(clr3),
      .sel_o(sel3), .xr_i(xr3), .xi_i(xi3), .busy_o(busy3),
      .frame_valid_o(valid3), .frame_ready_i(ready3),
      .frame_xr_o(fxr3), .frame_xi_o(fxi3), .overrun_o(ovr3));

   function automatic int bin_of(input logic [2:0] s);
      case (s)
         3'b001:  return 1;
         3'b010:  return 2;
         3'b100:  return 3;
         default: return 0;
      endcase
   endfunction

   // SETTLE=1 butterfly: combinational, xr=bin+1+ofs, xi=-(bin+1+ofs)
   always_comb begin
      xr1 = 4'(bin_of(sel1) + 1 + ofs);
      xi1 = 4'(-(bin_of(sel1) + 1 + ofs));
   end

   // SETTLE=3 butterfly: output follows sel_o one cycle late
   always @(posedge clk) begin
      xr3 <= tab_xr[bin_of(sel3)];
      xi3 <= tab_xi[bin_of(sel3)];
   end

   function automatic logic [31:0] exp_frame(input int o);
      logic [15:0] xr, xi;
      for (int b = 0; b < 4; b++) begin
         xr[b*4 +: 4] = 4'(b + 1 + o);
         xi[b*4 +: 4] = 4'(-(b + 1 + o));
      end
      return {xi, xr};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step(input vec_t v);
      logic [31:0] e;
      start1 = v.start;
      ready1 = v.ready;
      clr1   = v.clr;
      ofs    = v.ofs;
      #1;
      if (valid1 && ready1) begin
         if (sb_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL hs_empty: got handshake expected none at %0t", $time);
         end else begin
            e = sb_q.pop_front();
            chk("hs_xr", {16'h0, fxr1}, {16'h0, e[15:0]});
            chk("hs_xi", {16'h0, fxi1}, {16'h0, e[31:16]});
         end
      end
      if (v.start && v.push) sb_q.push_back(exp_frame(v.ofs));
      @(posedge clk);
      #1;
      chk("sel", 32'(sel1), 32'(v.sel));
      chk("busy", 32'(busy1), 32'(v.busy));
      chk("valid", 32'(valid1), 32'(v.valid));
      chk("overrun", 32'(ovr1), 32'(v.ovr));
      if (v.valid) begin
         if (sb_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL hold_empty: got no pending frame expected one at %0t", $time);
         end else begin
            chk("hold_xr", {16'h0, fxr1}, {16'h0, sb_q[0][15:0]});
            chk("hold_xi", {16'h0, fxi1}, {16'h0, sb_q[0][31:16]});
         end
      end
   endtask

   task automatic run(input bit s, input bit r, input bit c, input bit p, input int o,
                      input logic [2:0] sel, input bit busy, input bit valid, input bit ovr);
      vec_t v;
      v = '{s, r, c, p, o, sel, busy, valid, ovr};
      step(v);
   endtask

   vec_t vecs [17];
   int   n;

   initial begin
      rst_n = 1'b0;
      start1 = 0; clr1 = 0; ready1 = 0;
      start3 = 0; clr3 = 0; ready3 = 0;

      //          start ready clr push ofs  sel   busy valid ovr
      vecs[0]  = '{1, 0, 0, 1, 0, 3'b000, 1, 0, 0};
      vecs[1]  = '{0, 0, 0, 0, 0, 3'b001, 1, 0, 0};
      vecs[2]  = '{0, 0, 0, 0, 0, 3'b010, 1, 0, 0};
      vecs[3]  = '{0, 0, 0, 0, 0, 3'b100, 1, 0, 0};
      vecs[4]  = '{0, 0, 0, 0, 0, 3'b100, 1, 1, 0};
      vecs[5]  = '{0, 0, 0, 0, 0, 3'b100, 1, 1, 0};
      vecs[6]  = '{1, 0, 0, 0, 0, 3'b100, 1, 1, 1};
      vecs[7]  = '{0, 0, 1, 0, 0, 3'b100, 1, 1, 0};
      vecs[8]  = '{1, 0, 1, 0, 0, 3'b100, 1, 1, 1};
      vecs[9]  = '{0, 0, 1, 0, 0, 3'b100, 1, 1, 0};
      vecs[10] = '{1, 1, 0, 1, 4, 3'b000, 1, 0, 0};
      vecs[11] = '{1, 0, 0, 0, 4, 3'b001, 1, 0, 1};
      vecs[12] = '{0, 0, 1, 0, 4, 3'b010, 1, 0, 0};
      vecs[13] = '{0, 0, 0, 0, 4, 3'b100, 1, 0, 0};
      vecs[14] = '{0, 1, 0, 0, 4, 3'b100, 1, 1, 0};
      vecs[15] = '{0, 1, 0, 0, 4, 3'b100, 0, 0, 0};
      vecs[16] = '{0, 0, 0, 0, 4, 3'b100, 0, 0, 0};

      repeat (2) @(posedge clk);
      #1;
      chk("rst_sel", 32'(sel1), 32'h0);
      chk("rst_busy", 32'(busy1), 32'h0);
      chk("rst_valid", 32'(valid1), 32'h0);
      chk("rst_ovr", 32'(ovr1), 32'h0);
      chk("rst_frame", {fxi1, fxr1}, 32'h0);
      chk("rst_busy3", 32'(busy3), 32'h0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      for (int i = 0; i < 17; i++) begin
         step(vecs[i]);
         if (i == 4) chk("frame0_const", {fxi1, fxr1}, {16'hCDEF, 16'h4321});
      end
      chk("retain_after_hs", {fxi1, fxr1}, {16'h89AB, 16'h8765});
      ready1 = 0; start1 = 0; clr1 = 0;

      // SETTLE=3 instance: capture waits for the late-settling model
      start3 = 1;
      @(posedge clk);
      #1;
      start3 = 0;
      chk("s3_sel0", 32'(sel3), 32'h0);
      n = 0;
      while (!valid3 && n < 40) begin
         @(posedge clk);
         #1;
         n++;
         if (n < 12) chk("s3_sel", 32'(sel3), 32'(bin_sel_ref[n/3]));
      end
      chk("s3_valid_latency", 32'(n), 32'd12);
      chk("s3_frame_xr", {16'h0, fxr3}, 32'h0000C3A5);
      chk("s3_frame_xi", {16'h0, fxi3}, 32'h00007E29);
      ready3 = 1;
      @(posedge clk);
      #1;
      ready3 = 0;
      chk("s3_idle", 32'(busy3), 32'h0);

      // Reset in the middle of a frame, while bin 2 is being captured
      run(1, 0, 0, 1, 8, 3'b000, 1, 0, 0);
      run(0, 0, 0, 0, 8, 3'b001, 1, 0, 0);
      run(0, 0, 0, 0, 8, 3'b010, 1, 0, 0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_sel", 32'(sel1), 32'h0);
      chk("arst_busy", 32'(busy1), 32'h0);
      chk("arst_valid", 32'(valid1), 32'h0);
      chk("arst_ovr", 32'(ovr1), 32'h0);
      chk("arst_frame", {fxi1, fxr1}, 32'h0);
      sb_q.delete();
      #4;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("post_rst_idle", 32'(busy1), 32'h0);
      run(0, 0, 0, 0, 12, 3'b000, 0, 0, 0);
      run(1, 0, 0, 1, 12, 3'b000, 1, 0, 0);
      run(0, 0, 0, 0, 12, 3'b001, 1, 0, 0);
      run(0, 0, 0, 0, 12, 3'b010, 1, 0, 0);
      run(0, 0, 0, 0, 12, 3'b100, 1, 0, 0);
      run(0, 0, 0, 0, 12, 3'b100, 1, 1, 0);
      chk("clean_frame", {fxi1, fxr1}, {16'h0123, 16'h0FED});
      run(0, 1, 0, 0, 12, 3'b100, 0, 0, 0);
      chk("sb_drained", 32'(sb_q.size()), 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
